fetch_decode_skid_reg: RTL and testbench

//  Elastic IF/ID stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/fetch_decode_skid_reg.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_decode_skid_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_skid_reg.sv
// IF/ID elastic stage: valid/ready handshake with a 2-entry skid buffer, registered up_ready,
// synchronous flush to a NOP bubble, and saturating stall/flush counters.
module fetch_decode_skid_reg #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] instrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  down_valid,
    input  logic                  down_ready,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    localparam logic [DATA_WIDTH-1:0] NOP_D    = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] ZERO_D   = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1'b1);

    // State bits are {main_v, skid_v}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        LD_HOLD = 2'd0,
        LD_IN   = 2'd1,
        LD_SKID = 2'd2,
        LD_NOP  = 2'd3
    } main_ld_t;

    state_t                r_state;
    state_t                w_state_nxt;
    main_ld_t              w_main_ld;
    logic                  w_skid_ld;
    logic                  r_up_ready;
    logic                  w_main_v;
    logic                  w_skid_v;
    logic                  w_up_fire;
    logic                  w_dn_fire;
    logic                  w_stall_evt;
    logic                  w_flush_evt;
    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pc4_d;
    logic [DATA_WIDTH-1:0] r_skid_instr;
    logic [DATA_WIDTH-1:0] r_skid_pc;
    logic [DATA_WIDTH-1:0] r_skid_pc4;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    assign w_main_v    = r_state[1];
    assign w_skid_v    = r_state[0];
    assign w_up_fire   = up_valid & r_up_ready;
    assign w_dn_fire   = w_main_v & down_ready;
    assign w_stall_evt = w_main_v & ~down_ready;
    assign w_flush_evt = flush & (w_main_v | w_skid_v);

    // Next-state and load-select logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = LD_HOLD;
        w_skid_ld   = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_ld   = LD_NOP;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_up_fire) begin
                        w_state_nxt = ST_FULL;
                        w_main_ld   = LD_IN;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_dn_fire && w_up_fire) begin
                        w_main_ld   = LD_IN;
                    end else if (w_dn_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_ld   = LD_NOP;
                    end else if (w_up_fire) begin
                        w_state_nxt = ST_SKID;
                        w_skid_ld   = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (w_dn_fire) begin
                        w_state_nxt = ST_FULL;
                        w_main_ld   = LD_SKID;
                    end else begin
                        w_state_nxt = ST_SKID;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_ld   = LD_NOP;
                end
            endcase
        end
    end

    // State register; ready is derived from the next state so a drain reopens it one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_up_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_up_ready <= (w_state_nxt != ST_SKID);
        end
    end

    // Main payload doubles as the output register, so the NOP/0 bubble is loaded when it empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d <= NOP_D;
            r_pc_d    <= ZERO_D;
            r_pc4_d   <= ZERO_D;
        end else begin
            case (w_main_ld)
                LD_IN: begin
                    r_instr_d <= instrF;
                    r_pc_d    <= PCF;
                    r_pc4_d   <= PCPlus4F;
                end
                LD_SKID: begin
                    r_instr_d <= r_skid_instr;
                    r_pc_d    <= r_skid_pc;
                    r_pc4_d   <= r_skid_pc4;
                end
                LD_NOP: begin
                    r_instr_d <= NOP_D;
                    r_pc_d    <= ZERO_D;
                    r_pc4_d   <= ZERO_D;
                end
                default: begin
                    r_instr_d <= r_instr_d;
                    r_pc_d    <= r_pc_d;
                    r_pc4_d   <= r_pc4_d;
                end
            endcase
        end
    end

    // Skid payload captures the input only when main is stalled and fetch still fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_instr <= ZERO_D;
            r_skid_pc    <= ZERO_D;
            r_skid_pc4   <= ZERO_D;
        end else if (w_skid_ld) begin
            r_skid_instr <= instrF;
            r_skid_pc    <= PCF;
            r_skid_pc4   <= PCPlus4F;
        end else begin
            r_skid_instr <= r_skid_instr;
            r_skid_pc    <= r_skid_pc;
            r_skid_pc4   <= r_skid_pc4;
        end
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= CNT_ZERO;
            r_flush_cnt <= CNT_ZERO;
        end else begin
            r_stall_cnt <= w_stall_evt ? sat_inc(r_stall_cnt) : r_stall_cnt;
            r_flush_cnt <= w_flush_evt ? sat_inc(r_flush_cnt) : r_flush_cnt;
        end
    end

    assign up_ready   = r_up_ready;
    assign down_valid = w_main_v;
    assign instrD     = r_instr_d;
    assign PCD        = r_pc_d;
    assign PCPlus4D   = r_pc4_d;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Bench for fetch_decode_skid_reg: directed scenarios plus random traffic checked every cycle
// against a 2-deep queue model of the stage.
module tb_fetch_decode_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        down_valid;
    logic        down_ready;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        u4_valid;
    logic        u4_ready;
    logic        d4_valid;
    logic        d4_ready;
    logic [31:0] i4_d;
    logic [31:0] p4_d;
    logic [31:0] p44_d;
    logic [3:0]  s4_cnt;
    logic [3:0]  f4_cnt;

    always #5 clk = ~clk;

    fetch_decode_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready),
        .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .down_valid(down_valid), .down_ready(down_ready),
        .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_decode_skid_reg #(.DATA_WIDTH(32), .NOP_INSTR(32'h00000013), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .up_valid(u4_valid), .up_ready(u4_ready),
        .instrF(32'h0000_0001), .PCF(32'h0000_0100), .PCPlus4F(32'h0000_0104),
        .down_valid(d4_valid), .down_ready(d4_ready),
        .instrD(i4_d), .PCD(p4_d), .PCPlus4D(p44_d),
        .stall_cnt(s4_cnt), .flush_cnt(f4_cnt)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t        q[$];
    bit          m_ready;
    int unsigned m_stall;
    int unsigned m_flush;
    bit          m_uf;
    bit          m_df;
    logic        e_v;
    logic [31:0] e_i;
    logic [31:0] e_p;
    logic [31:0] e_p4;
    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of at most two entries; ready means fewer than two held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b1;
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_uf = up_valid && m_ready;
            m_df = (q.size() > 0) && down_ready;
            if (q.size() > 0 && !down_ready && m_stall < 32'd65535) m_stall++;
            if (flush) begin
                if (q.size() > 0 && m_flush < 32'd65535) m_flush++;
                q.delete();
            end else begin
                if (m_df) void'(q.pop_front());
                if (m_uf) q.push_back('{instrF, PCF, PCPlus4F});
            end
            m_ready = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0) begin
                e_v = 1'b1; e_i = q[0].instr; e_p = q[0].pc; e_p4 = q[0].pc4;
            end else begin
                e_v = 1'b0; e_i = 32'h00000013; e_p = 32'h0; e_p4 = 32'h0;
            end
            chk("down_valid", 32'(down_valid), 32'(e_v));
            chk("instrD", instrD, e_i);
            chk("PCD", PCD, e_p);
            chk("PCPlus4D", PCPlus4D, e_p4);
            chk("up_ready", 32'(up_ready), 32'(m_ready));
            chk("stall_cnt", 32'(stall_cnt), m_stall);
            chk("flush_cnt", 32'(flush_cnt), m_flush);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input logic [31:0] pc);
        up_valid   = v;
        down_ready = r;
        flush      = f;
        PCF        = pc;
        PCPlus4F   = pc + 32'd4;
        instrF     = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
        instrF = 32'h0; PCF = 32'h0; PCPlus4F = 32'h0;
        u4_valid = 1'b0; d4_ready = 1'b0;
        step(); step();
        chk("rst_dv", 32'(down_valid), 32'h0);
        chk("rst_rdy", 32'(up_ready), 32'h1);
        chk("rst_instr", instrD, 32'h00000013);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(4 * i));
            step();
            chk("stream_dv", 32'(down_valid), 32'h1);
            chk("stream_pcd", PCD, 32'(4 * i));
            chk("stream_rdy", 32'(up_ready), 32'h1);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("drain_dv", 32'(down_valid), 32'h0);

        drive(1'b1, 1'b0, 1'b0, 32'h10); step();
        chk("stall_pcd0", PCD, 32'h10);
        drive(1'b1, 1'b0, 1'b0, 32'h14); step();
        chk("stall_rdy", 32'(up_ready), 32'h0);
        chk("stall_cnt1", 32'(stall_cnt), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h18);
        repeat (3) step();
        chk("stall_cnt4", 32'(stall_cnt), 32'h4);
        chk("stall_pcd1", PCD, 32'h10);
        drive(1'b0, 1'b1, 1'b0, 32'h0); step();
        chk("release_pcd", PCD, 32'h14);
        chk("release_rdy", 32'(up_ready), 32'h1);
        step();
        chk("release_dv", 32'(down_valid), 32'h0);

        drive(1'b1, 1'b0, 1'b0, 32'h20); step();
        drive(1'b1, 1'b0, 1'b0, 32'h24); step();
        chk("skid_rdy", 32'(up_ready), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h18); step();
        chk("flush_dv", 32'(down_valid), 32'h0);
        chk("flush_instr", instrD, 32'h00000013);
        chk("flush_pcd", PCD, 32'h0);
        chk("flush_cnt1", 32'(flush_cnt), 32'h1);
        chk("flush_rdy", 32'(up_ready), 32'h1);
        chk("flush_stall", 32'(stall_cnt), 32'h6);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) begin
            step();
            chk("post_flush_dv", 32'(down_valid), 32'h0);
        end

        drive(1'b1, 1'b0, 1'b0, 32'h30); step();
        drive(1'b1, 1'b0, 1'b0, 32'h34); step();
        chk("pre_rst_rdy", 32'(up_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dv", 32'(down_valid), 32'h0);
        chk("arst_rdy", 32'(up_ready), 32'h1);
        chk("arst_instr", instrD, 32'h00000013);
        chk("arst_pcd", PCD, 32'h0);
        chk("arst_pc4d", PCPlus4D, 32'h0);
        chk("arst_stall", 32'(stall_cnt), 32'h0);
        chk("arst_flush", 32'(flush_cnt), 32'h0);
        chk("arst_stall4", 32'(s4_cnt), 32'h0);
        step();
        rst_n    = 1'b1;
        u4_valid = 1'b1;
        d4_ready = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 3, $urandom);
            step();
            if (i == 14) chk("sat_count14", 32'(s4_cnt), 32'd14);
            if (i == 19) chk("sat_hold20", 32'(s4_cnt), 32'd15);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) step();
        chk("final_dv", 32'(down_valid), 32'h0);
        chk("sat_final", 32'(s4_cnt), 32'd15);
        chk("sat_dv4", 32'(d4_valid), 32'h1);
        chk("sat_flush4", 32'(f4_cnt), 32'h0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
